// File: rtl/mem_arbiter_rr_pkg.sv
// Shared constants and request-entry layout for the frame-buffer memory arbiter.
// An entry is packed as {wr, address, data}, with the data field in the low bits.
package mem_arbiter_rr_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int entryWidth(input int addrWidth, input int dataWidth);
        return 1 + addrWidth + dataWidth;
    endfunction

    function automatic int entryDataLsb(input int addrWidth, input int dataWidth);
        return 0;
    endfunction

    function automatic int entryAddrLsb(input int addrWidth, input int dataWidth);
        return dataWidth;
    endfunction

    function automatic int entryWrBit(input int addrWidth, input int dataWidth);
        return addrWidth + dataWidth;
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Per-port synchronous request FIFO. A push is refused while full, even if the
// same cycle also pops, so full is decoded from the registered count only.
module arb_req_fifo
    import mem_arbiter_rr_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full     = (r_count == (PTR_W+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign head     = r_mem[r_rdPtr];
    assign w_doPush = push & ~full;
    assign w_doPop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= push_data;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port frame-buffer RAM arbiter: per-port request FIFOs, one grant per cycle
// (round-robin or fixed priority), a registered issue stage and a read-return tag pipeline.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 16,
    parameter int PERIPHERALS   = 2,
    parameter int FIFO_DEPTH    = 16,
    parameter int RD_LATENCY    = 1,
    parameter int ARB_MODE      = 0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0] address,
    input  logic [PERIPHERALS-1:0]              wr,
    input  logic [DATA_WIDTH*PERIPHERALS-1:0]   data_in,
    input  logic [PERIPHERALS-1:0]              data_in_ready,
    output logic [PERIPHERALS-1:0]              fifo_full,
    output logic [PERIPHERALS-1:0]              overflow,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic [PERIPHERALS-1:0]              data_out_ready,
    output logic                                mem_en,
    output logic                                mem_wr,
    output logic [ADDRESS_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    input  logic [DATA_WIDTH-1:0]               mem_rdata
);

    localparam int EW       = entryWidth(ADDRESS_WIDTH, DATA_WIDTH);
    localparam int DATA_LSB = entryDataLsb(ADDRESS_WIDTH, DATA_WIDTH);
    localparam int ADDR_LSB = entryAddrLsb(ADDRESS_WIDTH, DATA_WIDTH);
    localparam int WR_BIT   = entryWrBit(ADDRESS_WIDTH, DATA_WIDTH);
    localparam int ID_W     = (PERIPHERALS > 1) ? clog2(PERIPHERALS) : 1;

    logic [EW-1:0]            w_head [PERIPHERALS];
    logic [PERIPHERALS-1:0]   w_empty;
    logic [PERIPHERALS-1:0]   w_full;
    logic [PERIPHERALS-1:0]   w_pop;
    logic                     w_grantValid;
    logic [ID_W-1:0]          w_grantId;
    logic [EW-1:0]            w_grantEntry;

    logic [ID_W-1:0]          r_lastGrant;
    logic [PERIPHERALS-1:0]   r_overflow;
    logic                     r_memEn;
    logic                     r_memWr;
    logic [ADDRESS_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0]    r_memWdata;
    logic [RD_LATENCY:0]      r_tagValid;
    logic [ID_W-1:0]          r_tagId [RD_LATENCY+1];
    logic [DATA_WIDTH-1:0]    r_dataOut;
    logic [PERIPHERALS-1:0]   r_dataOutReady;

    for (genvar gi = 0; gi < PERIPHERALS; gi++) begin : g_port
        arb_req_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (data_in_ready[gi]),
            .push_data ({wr[gi], address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                         data_in[gi*DATA_WIDTH +: DATA_WIDTH]}),
            .pop       (w_pop[gi]),
            .head      (w_head[gi]),
            .empty     (w_empty[gi]),
            .full      (w_full[gi])
        );
    end

    // Candidates are scanned farthest-first so the nearest requester is the last to assign.
    always_comb begin
        int idx;
        idx          = 0;
        w_grantValid = 1'b0;
        w_grantId    = '0;
        w_pop        = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int k = PERIPHERALS - 1; k >= 0; k--) begin
                if (!w_empty[k]) begin
                    w_grantValid = 1'b1;
                    w_grantId    = ID_W'(k);
                end
            end
        end else begin
            for (int k = PERIPHERALS; k >= 1; k--) begin
                idx = (int'(r_lastGrant) + k) % PERIPHERALS;
                if (!w_empty[idx]) begin
                    w_grantValid = 1'b1;
                    w_grantId    = ID_W'(idx);
                end
            end
        end
        if (w_grantValid) w_pop[w_grantId] = 1'b1;
    end

    assign w_grantEntry = w_head[w_grantId];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | (data_in_ready & w_full);
        end
    end

    // Writes enter the tag pipeline as invalid so they never raise a return strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastGrant    <= ID_W'(PERIPHERALS - 1);
            r_memEn        <= 1'b0;
            r_memWr        <= 1'b0;
            r_memAddr      <= '0;
            r_memWdata     <= '0;
            r_tagValid     <= '0;
            for (int s = 0; s <= RD_LATENCY; s++) r_tagId[s] <= '0;
            r_dataOut      <= '0;
            r_dataOutReady <= '0;
        end else begin
            r_memEn <= w_grantValid;
            r_memWr <= w_grantValid & w_grantEntry[WR_BIT];
            if (w_grantValid) begin
                r_lastGrant <= w_grantId;
                r_memAddr   <= w_grantEntry[ADDR_LSB +: ADDRESS_WIDTH];
                r_memWdata  <= w_grantEntry[DATA_LSB +: DATA_WIDTH];
            end
            r_tagValid[0] <= w_grantValid & ~w_grantEntry[WR_BIT];
            r_tagId[0]    <= w_grantId;
            for (int s = 1; s <= RD_LATENCY; s++) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagId[s]    <= r_tagId[s-1];
            end
            r_dataOutReady <= '0;
            if (r_tagValid[RD_LATENCY]) begin
                r_dataOutReady[r_tagId[RD_LATENCY]] <= 1'b1;
                r_dataOut <= mem_rdata;
            end
        end
    end

    assign fifo_full      = w_full;
    assign overflow       = r_overflow;
    assign mem_en         = r_memEn;
    assign mem_wr         = r_memWr;
    assign mem_addr       = r_memAddr;
    assign mem_wdata      = r_memWdata;
    assign data_out       = r_dataOut;
    assign data_out_ready = r_dataOutReady;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance share one
// stimulus stream, each backed by its own one-cycle-latency RAM model.
module tb_mem_arbiter_rr;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW*NP-1:0] address = '0;
    logic [NP-1:0]   wr = '0;
    logic [DW*NP-1:0] data_in = '0;
    logic [NP-1:0]   data_in_ready = '0;

    logic [NP-1:0] fullRr, ovfRr, rdyRr, fullFx, ovfFx, rdyFx;
    logic [DW-1:0] doutRr, wdataRr, rdataRr, doutFx, wdataFx, rdataFx;
    logic [AW-1:0] addrRr, addrFx;
    logic          enRr, wrRr, enFx, wrFx;

    logic [DW-1:0] ramRr [2**AW];
    logic [DW-1:0] ramFx [2**AW];
    bit            writtenRr [2**AW];
    bit            writtenFx [2**AW];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PERIPHERALS(NP),
                     .FIFO_DEPTH(16), .RD_LATENCY(1), .ARB_MODE(0)) dutRr (
        .clk(clk), .reset_n(reset_n), .address(address), .wr(wr), .data_in(data_in),
        .data_in_ready(data_in_ready), .fifo_full(fullRr), .overflow(ovfRr),
        .data_out(doutRr), .data_out_ready(rdyRr), .mem_en(enRr), .mem_wr(wrRr),
        .mem_addr(addrRr), .mem_wdata(wdataRr), .mem_rdata(rdataRr));

    mem_arbiter_rr #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PERIPHERALS(NP),
                     .FIFO_DEPTH(16), .RD_LATENCY(1), .ARB_MODE(1)) dutFx (
        .clk(clk), .reset_n(reset_n), .address(address), .wr(wr), .data_in(data_in),
        .data_in_ready(data_in_ready), .fifo_full(fullFx), .overflow(ovfFx),
        .data_out(doutFx), .data_out_ready(rdyFx), .mem_en(enFx), .mem_wr(wrFx),
        .mem_addr(addrFx), .mem_wdata(wdataFx), .mem_rdata(rdataFx));

    // Unwritten RAM words read back a fixed pattern; 0x0010 is preloaded with 0xBEEF.
    function automatic logic [DW-1:0] defaultWord(input logic [AW-1:0] a);
        return (a == 14'h0010) ? 16'hBEEF : (16'hA000 ^ {2'b00, a});
    endfunction

    function automatic logic [DW-1:0] peekFx(input logic [AW-1:0] a);
        return writtenFx[a] ? ramFx[a] : defaultWord(a);
    endfunction

    // RAM models: writes commit at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (enRr) begin
            if (wrRr) begin
                ramRr[addrRr] <= wdataRr;
                writtenRr[addrRr] <= 1'b1;
            end else begin
                rdataRr <= writtenRr[addrRr] ? ramRr[addrRr] : defaultWord(addrRr);
            end
        end
        if (enFx) begin
            if (wrFx) begin
                ramFx[addrFx] <= wdataFx;
                writtenFx[addrFx] <= 1'b1;
            end else begin
                rdataFx <= writtenFx[addrFx] ? ramFx[addrFx] : defaultWord(addrFx);
            end
        end
    end

    typedef struct {
        logic [1:0]    strobe;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          rrEn;
        logic [AW-1:0] rrAddr;
        logic [1:0]    rrRdy;
        logic [DW-1:0] rrData;
        logic          fxEn;
        logic [AW-1:0] fxAddr;
        logic [1:0]    fxRdy;
        logic [DW-1:0] fxData;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of requests, then samples just after the edge.
    task automatic applyStimulus(input logic [1:0] strobe, input logic [1:0] wrIn,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        data_in_ready = strobe;
        wr            = wrIn;
        address       = {a1, a0};
        data_in       = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic doReset();
        data_in_ready = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_fifo_full", {30'd0, fullRr}, 32'd0);
        checkOutput("rst_overflow", {30'd0, ovfRr}, 32'd0);
        checkOutput("rst_data_out", {16'd0, doutRr}, 32'd0);
        checkOutput("rst_data_out_ready", {30'd0, rdyRr}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, enRr}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, wrRr}, 32'd0);
        checkOutput("rst_mem_addr", {18'd0, addrRr}, 32'd0);
        checkOutput("rst_mem_wdata", {16'd0, wdataRr}, 32'd0);
        checkOutput("rst_fx_outputs", {fullFx, ovfFx, rdyFx, enFx, wrFx, addrFx}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read from port 0.
        for (int s = 0; s < 5; s++) begin
            if (s == 0) applyStimulus(2'b01, 2'b00, 14'h0010, '0, '0, '0);
            else        idleStep();
            checkOutput($sformatf("single_mem_en_s%0d", s), {31'd0, enRr}, {31'd0, s == 1});
            checkOutput($sformatf("single_rdy_s%0d", s), {30'd0, rdyRr}, (s == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("single_mem_addr", {18'd0, addrRr}, 32'h0010);
        checkOutput("single_data_out", {16'd0, doutRr}, 32'hBEEF);

        // Interleaved reads on both ports: round-robin versus fixed priority.
        doReset();
        vecs[0] = '{2'b11, 14'h20, 14'h30, 1'b0, 14'h00, 2'b00, 16'h0000, 1'b0, 14'h00, 2'b00, 16'h0000};
        vecs[1] = '{2'b11, 14'h21, 14'h31, 1'b1, 14'h20, 2'b00, 16'h0000, 1'b1, 14'h20, 2'b00, 16'h0000};
        vecs[2] = '{2'b11, 14'h22, 14'h32, 1'b1, 14'h30, 2'b00, 16'h0000, 1'b1, 14'h21, 2'b00, 16'h0000};
        vecs[3] = '{2'b00, 14'h00, 14'h00, 1'b1, 14'h21, 2'b01, 16'hA020, 1'b1, 14'h22, 2'b01, 16'hA020};
        vecs[4] = '{2'b00, 14'h00, 14'h00, 1'b1, 14'h31, 2'b10, 16'hA030, 1'b1, 14'h30, 2'b01, 16'hA021};
        vecs[5] = '{2'b00, 14'h00, 14'h00, 1'b1, 14'h22, 2'b01, 16'hA021, 1'b1, 14'h31, 2'b01, 16'hA022};
        vecs[6] = '{2'b00, 14'h00, 14'h00, 1'b1, 14'h32, 2'b10, 16'hA031, 1'b1, 14'h32, 2'b10, 16'hA030};
        vecs[7] = '{2'b00, 14'h00, 14'h00, 1'b0, 14'h00, 2'b01, 16'hA022, 1'b0, 14'h00, 2'b10, 16'hA031};
        vecs[8] = '{2'b00, 14'h00, 14'h00, 1'b0, 14'h00, 2'b10, 16'hA032, 1'b0, 14'h00, 2'b10, 16'hA032};
        vecs[9] = '{2'b00, 14'h00, 14'h00, 1'b0, 14'h00, 2'b00, 16'h0000, 1'b0, 14'h00, 2'b00, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].strobe, 2'b00, vecs[i].a0, vecs[i].a1, '0, '0);
            checkOutput($sformatf("rr_en_%0d", i), {31'd0, enRr}, {31'd0, vecs[i].rrEn});
            checkOutput($sformatf("fx_en_%0d", i), {31'd0, enFx}, {31'd0, vecs[i].fxEn});
            if (vecs[i].rrEn) checkOutput($sformatf("rr_addr_%0d", i), {18'd0, addrRr}, {18'd0, vecs[i].rrAddr});
            if (vecs[i].fxEn) checkOutput($sformatf("fx_addr_%0d", i), {18'd0, addrFx}, {18'd0, vecs[i].fxAddr});
            checkOutput($sformatf("rr_rdy_%0d", i), {30'd0, rdyRr}, {30'd0, vecs[i].rrRdy});
            checkOutput($sformatf("fx_rdy_%0d", i), {30'd0, rdyFx}, {30'd0, vecs[i].fxRdy});
            if (vecs[i].rrRdy != 2'b00) checkOutput($sformatf("rr_data_%0d", i), {16'd0, doutRr}, {16'd0, vecs[i].rrData});
            if (vecs[i].fxRdy != 2'b00) checkOutput($sformatf("fx_data_%0d", i), {16'd0, doutFx}, {16'd0, vecs[i].fxData});
        end

        // Fixed priority: index 0 hogs the RAM while index 1 overfills its FIFO.
        doReset();
        for (int s = 0; s <= 16; s++) begin
            applyStimulus(2'b11, 2'b10, 14'h0000, 14'h0100 + 14'(s), '0, 16'h5000 + 16'(s));
            if (s == 14) checkOutput("fx_full_after15", {31'd0, fullFx[1]}, 32'd0);
            if (s == 15) checkOutput("fx_full_after16", {31'd0, fullFx[1]}, 32'd1);
            if (s == 16) checkOutput("fx_overflow", {30'd0, ovfFx}, 32'd2);
        end
        idleStep();
        checkOutput("fx_full_before_pop", {31'd0, fullFx[1]}, 32'd1);
        applyStimulus(2'b10, 2'b10, '0, 14'h01F0, '0, 16'hDEAD);
        checkOutput("fx_full_after_pop", {31'd0, fullFx[1]}, 32'd0);
        checkOutput("fx_first_write_issue", {31'd0, wrFx}, 32'd1);
        repeat (25) idleStep();
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("fx_ram_%0d", k), {16'd0, peekFx(14'h0100 + 14'(k))}, 32'h5000 + 32'(k));
        end
        checkOutput("fx_ram_dropped17", {16'd0, peekFx(14'h0110)}, {16'd0, defaultWord(14'h0110)});
        checkOutput("fx_ram_refused_full_pop", {16'd0, peekFx(14'h01F0)}, {16'd0, defaultWord(14'h01F0)});
        checkOutput("fx_overflow_sticky", {30'd0, ovfFx}, 32'd2);

        // Write from port 0 then read-back from port 1.
        doReset();
        for (int s = 0; s < 7; s++) begin
            if (s == 0)      applyStimulus(2'b01, 2'b01, 14'h0005, '0, 16'h1234, '0);
            else if (s == 1) applyStimulus(2'b10, 2'b00, '0, 14'h0005, '0, '0);
            else             idleStep();
            if (s == 1) begin
                checkOutput("wr_mem_wr", {31'd0, wrRr}, 32'd1);
                checkOutput("wr_mem_wdata", {16'd0, wdataRr}, 32'h1234);
                checkOutput("wr_mem_addr", {18'd0, addrRr}, 32'h0005);
            end
            if (s == 2) checkOutput("rd_mem_wr", {31'd0, wrRr}, 32'd0);
            checkOutput($sformatf("wr_rd_rdy_s%0d", s), {30'd0, rdyRr}, (s == 4) ? 32'd2 : 32'd0);
        end
        checkOutput("wr_rd_data", {16'd0, doutRr}, 32'h1234);

        // Reset with reads in flight: nothing is ever strobed and port 0 wins afterwards.
        doReset();
        applyStimulus(2'b01, 2'b00, 14'h0050, '0, '0, '0);
        applyStimulus(2'b01, 2'b00, 14'h0051, '0, '0, '0);
        applyStimulus(2'b01, 2'b00, 14'h0052, '0, '0, '0);
        data_in_ready = '0;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_outputs", {fullRr, ovfRr, rdyRr, enRr, wrRr, addrRr}, 32'd0);
        checkOutput("midrst_data", {doutRr, wdataRr}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("midrst_hold_rdy_%0d", s), {30'd0, rdyRr}, 32'd0);
        end
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            idleStep();
            checkOutput($sformatf("postrst_quiet_%0d", s), {29'd0, rdyRr, enRr}, 32'd0);
        end
        applyStimulus(2'b11, 2'b00, 14'h0060, 14'h0061, '0, '0);
        idleStep();
        checkOutput("postrst_first_grant", {17'd0, enRr, addrRr}, {17'd0, 1'b1, 14'h0060});
        idleStep();
        checkOutput("postrst_second_grant", {17'd0, enRr, addrRr}, {17'd0, 1'b1, 14'h0061});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
